// File: rtl/cordic_atan_arb.sv
// Round-robin share of one vectoring CORDIC between two requesters.
// In-order tag FIFO steers each angle result back to its issuer.
module cordic_atan_arb #(
  parameter int DATA_W = 80,
  parameter int OUT_W  = 24,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  output logic              c_tvalid,
  input  logic              c_tready,
  output logic [DATA_W-1:0] c_tdata,
  input  logic              c_dout_tvalid,
  input  logic [OUT_W-1:0]  c_dout_tdata,
  output logic              r0_vld,
  output logic [OUT_W-1:0]  r0_data,
  output logic              r1_vld,
  output logic [OUT_W-1:0]  r1_data,
  output logic              busy,
  output logic              err_orphan
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          tags [DEPTH];
  logic          last;
  logic          slot_free;
  logic          can_grant;
  logic          g0;
  logic          g1;
  logic          push;
  logic          pop;
  logic          head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign slot_free = !c_tvalid || c_tready;
  assign can_grant = slot_free && (cnt < CW'(DEPTH));

  // last holds the most recent winner; the other side wins a tie
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (can_grant) begin
      unique case (1'b1)
        (s0_tvalid && (!s1_tvalid || last)):  g0 = 1'b1;
        (s1_tvalid && (!s0_tvalid || !last)): g1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign s0_tready = g0;
  assign s1_tready = g1;
  assign push      = g0 || g1;
  assign pop       = c_dout_tvalid && (cnt != '0);
  assign head      = tags[rd_ptr];
  assign cnt_nxt   = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= g1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last       <= 1'b1;
      c_tvalid   <= 1'b0;
      c_tdata    <= '0;
      r0_vld     <= 1'b0;
      r0_data    <= '0;
      r1_vld     <= 1'b0;
      r1_data    <= '0;
      busy       <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      busy   <= (cnt_nxt != '0);
      r0_vld <= 1'b0;
      r1_vld <= 1'b0;
      if (push) begin
        wr_ptr   <= inc(wr_ptr);
        last     <= g1;
        c_tvalid <= 1'b1;
        c_tdata  <= g1 ? s1_tdata : s0_tdata;
      end else if (c_tready) begin
        c_tvalid <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
        if (head) begin
          r1_vld  <= 1'b1;
          r1_data <= c_dout_tdata;
        end else begin
          r0_vld  <= 1'b1;
          r0_data <= c_dout_tdata;
        end
      end else if (c_dout_tvalid) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_atan_arb.sv
// Scoreboard bench for cordic_atan_arb with a latency-modelled CORDIC.
// Directed scenarios followed by randomized traffic.
module tb_cordic_atan_arb;
  localparam int DATA_W = 80;
  localparam int OUT_W  = 24;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              s0_tvalid;
  logic              s0_tready;
  logic [DATA_W-1:0] s0_tdata;
  logic              s1_tvalid;
  logic              s1_tready;
  logic [DATA_W-1:0] s1_tdata;
  logic              c_tvalid;
  logic              c_tready;
  logic [DATA_W-1:0] c_tdata;
  logic              c_dout_tvalid;
  logic [OUT_W-1:0]  c_dout_tdata;
  logic              r0_vld;
  logic [OUT_W-1:0]  r0_data;
  logic              r1_vld;
  logic [OUT_W-1:0]  r1_data;
  logic              busy;
  logic              err_orphan;

  cordic_atan_arb #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s0_tvalid    (s0_tvalid),
    .s0_tready    (s0_tready),
    .s0_tdata     (s0_tdata),
    .s1_tvalid    (s1_tvalid),
    .s1_tready    (s1_tready),
    .s1_tdata     (s1_tdata),
    .c_tvalid     (c_tvalid),
    .c_tready     (c_tready),
    .c_tdata      (c_tdata),
    .c_dout_tvalid(c_dout_tvalid),
    .c_dout_tdata (c_dout_tdata),
    .r0_vld       (r0_vld),
    .r0_data      (r0_data),
    .r1_vld       (r1_vld),
    .r1_data      (r1_data),
    .busy         (busy),
    .err_orphan   (err_orphan)
  );

  typedef struct {
    int               due;
    logic [OUT_W-1:0] d;
  } ce_t;

  typedef struct {
    int               due;
    bit               port;
    logic [OUT_W-1:0] d;
  } ex_t;

  ce_t cq[$];
  ex_t exq[$];
  bit  tags[$];

  int cyc    = 0;
  int lat    = 20;
  int total  = 0;
  int passed = 0;

  bit                m_cv;
  bit                m_last = 1'b1;
  bit                m_err;
  logic [DATA_W-1:0] m_cd;
  logic [OUT_W-1:0]  m_r0d;
  logic [OUT_W-1:0]  m_r1d;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
  endtask

  // stand-in for the arctangent: any fixed function of the operand
  function automatic logic [OUT_W-1:0] ang(input logic [DATA_W-1:0] d);
    return (d[23:0] ^ d[63:40]) + 24'h013579;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_op();
    logic [33:0] x;
    logic [33:0] y;
    x = 34'({$urandom(), $urandom()});
    y = 34'({$urandom(), $urandom()});
    return {6'b0, y, 6'b0, x};
  endfunction

  // advance one cycle; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    c_dout_tvalid = 1'b0;
    if (cq.size() > 0 && cq[0].due == cyc) begin
      c_dout_tvalid = 1'b1;
      c_dout_tdata  = cq[0].d;
      void'(cq.pop_front());
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (tags.size() == 0 && exq.size() == 0 && cq.size() == 0) break;
      step();
    end
    chk("drain", 80'(tags.size() + exq.size() + cq.size()), 80'(0));
  endtask

  // monitor + reference model, sampled mid-cycle
  always @(negedge clk) begin
    bit  cg;
    bit  eg0;
    bit  eg1;
    bit  t;
    ex_t e;
    if (rst) begin
      m_cv   = 1'b0;
      m_last = 1'b1;
      m_err  = 1'b0;
      m_cd   = '0;
      m_r0d  = '0;
      m_r1d  = '0;
      tags.delete();
      exq.delete();
      cq.delete();
    end else begin
      cg  = (!m_cv || c_tready) && (tags.size() < DEPTH);
      eg0 = cg && s0_tvalid && (!s1_tvalid || m_last);
      eg1 = cg && s1_tvalid && (!s0_tvalid || !m_last);
      chk("ready", 80'({s1_tready, s0_tready}), 80'({eg1, eg0}));
      chk("c_tvalid", 80'(c_tvalid), 80'(m_cv));
      if (m_cv) chk("c_tdata", c_tdata, m_cd);
      chk("busy", 80'(busy), 80'(tags.size() != 0));
      chk("err_orphan", 80'(err_orphan), 80'(m_err));
      if (exq.size() > 0 && exq[0].due == cyc) begin
        e = exq.pop_front();
        chk("r_vld", 80'({r1_vld, r0_vld}), e.port ? 80'(2) : 80'(1));
        if (e.port) m_r1d = e.d;
        else m_r0d = e.d;
      end else begin
        chk("r_vld", 80'({r1_vld, r0_vld}), 80'(0));
      end
      chk("r0_data", 80'(r0_data), 80'(m_r0d));
      chk("r1_data", 80'(r1_data), 80'(m_r1d));
      if (c_tvalid && c_tready) cq.push_back('{cyc + lat, ang(c_tdata)});
      if (c_dout_tvalid) begin
        if (tags.size() > 0) begin
          t = tags.pop_front();
          exq.push_back('{cyc + 1, t, c_dout_tdata});
        end else begin
          m_err = 1'b1;
        end
      end
      if (eg0 || eg1) begin
        tags.push_back(eg1);
        m_cv   = 1'b1;
        m_cd   = eg1 ? s1_tdata : s0_tdata;
        m_last = eg1;
      end else if (c_tready) begin
        m_cv = 1'b0;
      end
    end
  end

  initial begin
    rst           = 1'b1;
    s0_tvalid     = 1'b0;
    s1_tvalid     = 1'b0;
    s0_tdata      = '0;
    s1_tdata      = '0;
    c_tready      = 1'b0;
    c_dout_tvalid = 1'b0;
    c_dout_tdata  = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_outs", 80'({c_tvalid, r0_vld, r1_vld, busy, err_orphan,
        s0_tready, s1_tready}), 80'(0));
    chk("rst_data", 80'({r0_data, r1_data}), 80'(0));
    chk("rst_ctdata", c_tdata, 80'(0));

    // single request, latency 20
    lat       = 20;
    c_tready  = 1'b1;
    s0_tdata  = {6'b0, 34'h100, 6'b0, 34'h100};
    s0_tvalid = 1'b1;
    step();
    s0_tvalid = 1'b0;
    wait_idle();

    // fairness: both requesters always valid
    lat       = 3;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    repeat (40) begin
      s0_tdata = rnd_op();
      s1_tdata = rnd_op();
      step();
    end
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    wait_idle();

    // CORDIC stall while both requesters keep asking
    c_tready  = 1'b0;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    repeat (6) begin
      s0_tdata = rnd_op();
      s1_tdata = rnd_op();
      step();
    end
    c_tready  = 1'b1;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    wait_idle();

    // outstanding limit with a long latency
    lat       = 20;
    s0_tvalid = 1'b1;
    repeat (30) begin
      s0_tdata = rnd_op();
      step();
    end
    s0_tvalid = 1'b0;
    wait_idle();

    // orphan result while idle
    c_dout_tvalid = 1'b1;
    c_dout_tdata  = 24'habcdef;
    repeat (4) step();
    chk("orphan_sticky", 80'(err_orphan), 80'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("orphan_clr", 80'(err_orphan), 80'(0));

    // reset with two operations in flight
    lat       = 20;
    s0_tvalid = 1'b1;
    s0_tdata  = rnd_op();
    step();
    s0_tdata  = rnd_op();
    step();
    s0_tvalid = 1'b0;
    chk("mid_pre", 80'({c_tvalid, busy}), 80'(3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_post", 80'({c_tvalid, busy, r0_vld, r1_vld}), 80'(0));
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    s0_tdata  = rnd_op();
    s1_tdata  = rnd_op();
    #1;
    chk("mid_first", 80'({s1_tready, s0_tready}), 80'(1));
    step();
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    wait_idle();

    // randomized traffic
    for (int p = 0; p < 3; p++) begin
      lat = $urandom_range(1, 8);
      repeat (300) begin
        s0_tvalid = 1'($urandom_range(0, 1));
        s1_tvalid = 1'($urandom_range(0, 1));
        s0_tdata  = rnd_op();
        s1_tdata  = rnd_op();
        c_tready  = ($urandom_range(0, 3) != 0);
        step();
      end
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
      c_tready  = 1'b1;
      wait_idle();
    end

    step();
    chk("final_empty", 80'(exq.size() + tags.size()), 80'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
